note_seq_ctrl: RTL and testbench
================================

Name: note_seq_ctrl

Overview:
Game sequencer for the note-following datapath. It steps a note index through a song ROM and enables the LED display of the target note. It then waits for the player's key press and grades it as hit or miss (wrong key or timeout). On a hit it gates the buzzer tone generator for a fixed duration, then advances to the next note. It replaces the free-running index counter with a timed, scored state machine.

Parameters:
SONG_LEN, 28, number of notes in the song (1..32)
IDX_W, 5, width of note_idx
TICK_DIV, 4686914, clk cycles per game tick
NOTE_TIMEOUT, 8, ticks allowed in WAIT before a miss
HOLD_TICKS, 2, ticks the buzzer plays after a hit

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; starts a song when sampled high in IDLE
abort  in  1  level; returns to IDLE from any state
key  in  8  debounced player keys, active-high
tgt_key  in  8  one-hot target key from song ROM for note_idx (combinational)
note_idx  out  IDX_W  current song position, drives ROM address
note_valid  out  1  high in ARM/WAIT/PLAY; enables LED display
play  out  1  high in PLAY; gates buzzer tone generator
hit_pulse  out  1  one-cycle pulse on a graded hit
miss_pulse  out  1  one-cycle pulse on a graded miss
hit_count  out  8  saturating hit total
miss_count  out  8  saturating miss total
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE

Behaviour:
- Reset: state=IDLE. All outputs, tick divider, timers and key_q are 0.
- Tick generator: a 23-bit counter counts 0..TICK_DIV-1 and emits a 1-cycle tick at wrap. It runs only while busy and is cleared on IDLE entry and on every state transition, so each timed phase starts a full period.
- Key edges: key_q <= key every cycle. new_press = key & ~key_q.
- IDLE: when start=1, clear counts and note_idx, then go to ARM.
- ARM: wait until key==0, then go to WAIT. This blocks a held key from grading the next note.
- WAIT:
  - new_press != 0 and new_press == tgt_key: hit, hit_pulse, go to PLAY.
  - new_press != 0 and new_press != tgt_key (wrong or multiple bits): miss, miss_pulse, go to ADV.
  - Otherwise the timeout counter increments per tick. When it reaches NOTE_TIMEOUT: miss, go to ADV.
  - A press in the same cycle as the timeout tick is graded as a press, so the key wins.
- PLAY: play=1 for HOLD_TICKS ticks, then go to ADV.
- ADV, one cycle:
  - If note_idx == SONG_LEN-1, go to DONE.
  - Otherwise note_idx+1, go to ARM.
  - note_idx never wraps.
- DONE: done=1; counts and note_idx are held. start=1 restarts as from IDLE.
- abort: highest priority after reset. From any state go to IDLE next cycle. play and busy drop, counts are held, note_idx is held.
- start while busy: ignored.
- Counts saturate at 255 and do not wrap.
- Grading latency: hit_pulse/miss_pulse assert 1 cycle after the key rising edge is visible on key. play asserts in the same cycle as hit_pulse.
- Asynchronous reset mid-song: everything returns to reset values immediately. No pulse is generated.

Decomposition:
- Package note_game_pkg:
  - State enum {IDLE, ARM, WAIT, PLAY, ADV, DONE}
  - KEY_W=8
  - Default SONG_LEN/TICK_DIV constants, shared with the song ROM and LED mapper
- Sub-module tick_gen (parameter DIV; ports clk, rst_n, clr, en -> tick), reused by the buzzer path.

Test Plan:
Sim settings: SONG_LEN=4, TICK_DIV=4, NOTE_TIMEOUT=3, HOLD_TICKS=2.
1. Perfect song: tgt_key=8'h01,02,04,08; press the matching key each WAIT -> four hit_pulses, play high 8 cycles per hit, hit_count=4, miss_count=0, done=1, note_idx=3.
2. Wrong key: in WAIT with tgt_key=8'h02, press 8'h04 -> miss_pulse the next cycle, play stays 0, note_idx advances 0->1; two-key press 8'h06 also -> miss.
3. Timeout: no press -> miss_pulse exactly 12 cycles after WAIT entry (3 ticks), note_idx increments; press coincident with the 3rd tick and correct -> hit, not miss.
4. Held key: hold key 8'h01 through the hit and into the next note -> FSM stays in ARM, no grading, until key=0; no double hit.
5. Abort and reset: abort in PLAY -> next cycle IDLE, play=0, busy=0, counts held. rst_n low mid-WAIT -> all outputs 0 immediately. Then start -> counts cleared, note_idx=0.
6. Saturation: force 300 hits with SONG_LEN=32 looped via restarts without clearing (start clears, so preload through a long song) -> hit_count stops at 255; start while busy is ignored and note_idx is unchanged.

Source files
------------

// File: rtl/note_game_pkg.sv
// Shared types and defaults for the note-following game: sequencer states,
// key width, song/tick defaults and a saturating counter helper.
package note_game_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        WAIT = 3'd2,
        PLAY = 3'd3,
        ADV  = 3'd4,
        DONE = 3'd5
    } state_e;

    localparam int KEY_W        = 8;
    localparam int SONG_LEN_DEF = 28;
    localparam int TICK_DIV_DEF = 4686914;
    localparam int TICK_CNT_W   = 23;
    localparam int CNT_W        = 8;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Game tick divider: one-cycle tick every DIV enabled cycles, restartable via clr.
module tick_gen
    import note_game_pkg::*;
#(
    parameter int DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [TICK_CNT_W-1:0] LAST = TICK_CNT_W'(DIV - 1);

    logic [TICK_CNT_W-1:0] cnt_r;

    // divider counter; clr has priority so every phase starts a full period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {TICK_CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {TICK_CNT_W{1'b0}};
        end else if (en) begin
            if (cnt_r == LAST) begin
                cnt_r <= {TICK_CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + TICK_CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = en && (cnt_r == LAST);

endmodule

// File: rtl/note_seq_ctrl.sv
// Note-following game sequencer: walks the song index, grades key presses as
// hit/miss with a tick-based timeout, and gates the buzzer after each hit.
module note_seq_ctrl
    import note_game_pkg::*;
#(
    parameter int SONG_LEN     = SONG_LEN_DEF,
    parameter int IDX_W        = 5,
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int NOTE_TIMEOUT = 8,
    parameter int HOLD_TICKS   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [KEY_W-1:0] key,
    input  logic [KEY_W-1:0] tgt_key,
    output logic [IDX_W-1:0] note_idx,
    output logic             note_valid,
    output logic             play,
    output logic             hit_pulse,
    output logic             miss_pulse,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SONG_LEN - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(NOTE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);

    state_e           state_r, state_next_s;
    logic [KEY_W-1:0] key_q_r, new_press_s;
    logic [CNT_W-1:0] phase_ticks_r, hit_count_r, miss_count_r;
    logic [IDX_W-1:0] note_idx_r;
    logic             tick_s, clr_s, press_s, timeout_s, hold_end_s;
    logic             hit_s, miss_s, restart_s;
    logic             note_valid_s, play_s, busy_s, done_s;
    logic             note_valid_r, play_r, busy_r, done_r, hit_pulse_r, miss_pulse_r;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .en    (busy_r),
        .tick  (tick_s)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // grading: a fresh press beats a timeout landing in the same cycle
    always_comb begin
        new_press_s = key & ~key_q_r;
        press_s     = |new_press_s;
        timeout_s   = tick_s && (phase_ticks_r == TMO_LAST);
        hold_end_s  = tick_s && (phase_ticks_r == HOLD_LAST);
        hit_s       = (state_r == WAIT) && !abort && press_s && (new_press_s == tgt_key);
        miss_s      = (state_r == WAIT) && !abort &&
                      (press_s ? (new_press_s != tgt_key) : timeout_s);
        restart_s   = ((state_r == IDLE) || (state_r == DONE)) && start && !abort;
    end

    // next-state logic; abort overrides every state
    always_comb begin
        state_next_s = state_r;
        if (abort) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE, DONE: state_next_s = start ? ARM : state_r;
                ARM:        state_next_s = (key == {KEY_W{1'b0}}) ? WAIT : ARM;
                WAIT: begin
                    if (hit_s) begin
                        state_next_s = PLAY;
                    end else if (miss_s) begin
                        state_next_s = ADV;
                    end else begin
                        state_next_s = WAIT;
                    end
                end
                PLAY:       state_next_s = hold_end_s ? ADV : PLAY;
                ADV:        state_next_s = (note_idx_r == LAST_IDX) ? DONE : ARM;
                default:    state_next_s = IDLE;
            endcase
        end
        clr_s = (state_next_s != state_r) || (state_r == IDLE);
    end

    // output decode of the upcoming state, registered below
    always_comb begin
        note_valid_s = (state_next_s == ARM) || (state_next_s == WAIT) || (state_next_s == PLAY);
        play_s       = (state_next_s == PLAY);
        busy_s       = (state_next_s != IDLE) && (state_next_s != DONE);
        done_s       = (state_next_s == DONE);
    end

    // datapath: key history, phase tick count, score, song position, outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q_r       <= {KEY_W{1'b0}};
            phase_ticks_r <= {CNT_W{1'b0}};
            hit_count_r   <= {CNT_W{1'b0}};
            miss_count_r  <= {CNT_W{1'b0}};
            note_idx_r    <= {IDX_W{1'b0}};
            note_valid_r  <= 1'b0;
            play_r        <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            hit_pulse_r   <= 1'b0;
            miss_pulse_r  <= 1'b0;
        end else begin
            key_q_r      <= key;
            note_valid_r <= note_valid_s;
            play_r       <= play_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            hit_pulse_r  <= hit_s;
            miss_pulse_r <= miss_s;
            if (clr_s) begin
                phase_ticks_r <= {CNT_W{1'b0}};
            end else if (tick_s && ((state_r == WAIT) || (state_r == PLAY))) begin
                phase_ticks_r <= phase_ticks_r + CNT_W'(1);
            end else begin
                phase_ticks_r <= phase_ticks_r;
            end
            if (restart_s) begin
                hit_count_r  <= {CNT_W{1'b0}};
                miss_count_r <= {CNT_W{1'b0}};
                note_idx_r   <= {IDX_W{1'b0}};
            end else begin
                hit_count_r  <= hit_s  ? sat_inc(hit_count_r)  : hit_count_r;
                miss_count_r <= miss_s ? sat_inc(miss_count_r) : miss_count_r;
                if ((state_r == ADV) && !abort && (note_idx_r != LAST_IDX)) begin
                    note_idx_r <= note_idx_r + IDX_W'(1);
                end else begin
                    note_idx_r <= note_idx_r;
                end
            end
        end
    end

    assign note_idx   = note_idx_r;
    assign note_valid = note_valid_r;
    assign play       = play_r;
    assign hit_pulse  = hit_pulse_r;
    assign miss_pulse = miss_pulse_r;
    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_note_seq_ctrl.sv
// Bench for note_seq_ctrl: cycle-deadline game model compared every cycle,
// directed songs with literal checks, and a long song for count saturation.
module tb_note_seq_ctrl;

    localparam int SL = 4, DIV = 4, NT = 3, HT = 2;
    localparam int P_IDLE = 0, P_ARM = 1, P_WAIT = 2, P_PLAY = 3, P_ADV = 4, P_DONE = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1, start = 1'b0, abort = 1'b0;
    logic [7:0] key = 8'h00, tgt_key;
    logic [4:0] note_idx;
    logic       note_valid, play, hit_pulse, miss_pulse, busy, done;
    logic [7:0] hit_count, miss_count;
    logic [7:0] rom [0:31];

    logic       rst2_n = 1'b1, start2 = 1'b0;
    logic [7:0] key2 = 8'h00;
    logic [8:0] note_idx2;
    logic       note_valid2, play2, hit_pulse2, miss_pulse2, busy2, done2;
    logic [7:0] hit_count2, miss_count2;

    int n_checks = 0, n_pass = 0, n_hitp = 0, n_playc = 0;

    always #5 clk = ~clk;
    assign tgt_key = rom[note_idx];

    note_seq_ctrl #(.SONG_LEN(SL), .IDX_W(5), .TICK_DIV(DIV), .NOTE_TIMEOUT(NT), .HOLD_TICKS(HT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key(key), .tgt_key(tgt_key),
        .note_idx(note_idx), .note_valid(note_valid), .play(play), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .hit_count(hit_count), .miss_count(miss_count),
        .busy(busy), .done(done));

    note_seq_ctrl #(.SONG_LEN(300), .IDX_W(9), .TICK_DIV(2), .NOTE_TIMEOUT(3), .HOLD_TICKS(1)) dut2 (
        .clk(clk), .rst_n(rst2_n), .start(start2), .abort(1'b0), .key(key2), .tgt_key(8'h01),
        .note_idx(note_idx2), .note_valid(note_valid2), .play(play2), .hit_pulse(hit_pulse2),
        .miss_pulse(miss_pulse2), .hit_count(hit_count2), .miss_count(miss_count2),
        .busy(busy2), .done(done2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: the game expressed as phases with cycle deadlines.
    logic [7:0] m_kq;
    int  m_ph, m_cyc, m_idx, m_hits, m_miss;
    logic m_hp, m_mp;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_kq <= 8'h00; m_ph <= P_IDLE; m_cyc <= 0; m_idx <= 0;
            m_hits <= 0; m_miss <= 0; m_hp <= 1'b0; m_mp <= 1'b0;
        end else begin
            m_kq <= key; m_hp <= 1'b0; m_mp <= 1'b0; m_cyc <= m_cyc + 1;
            if (abort) begin
                m_ph <= P_IDLE; m_cyc <= 0;
            end else begin
                case (m_ph)
                    P_IDLE, P_DONE: if (start) begin
                        m_ph <= P_ARM; m_cyc <= 0; m_idx <= 0; m_hits <= 0; m_miss <= 0;
                    end
                    P_ARM: if (key == 8'h00) begin m_ph <= P_WAIT; m_cyc <= 0; end
                    P_WAIT: begin
                        if ((key & ~m_kq) != 8'h00) begin
                            if ((key & ~m_kq) == rom[m_idx]) begin
                                m_hits <= (m_hits < 255) ? m_hits + 1 : 255;
                                m_hp <= 1'b1; m_ph <= P_PLAY; m_cyc <= 0;
                            end else begin
                                m_miss <= (m_miss < 255) ? m_miss + 1 : 255;
                                m_mp <= 1'b1; m_ph <= P_ADV; m_cyc <= 0;
                            end
                        end else if (m_cyc == NT * DIV - 1) begin
                            m_miss <= (m_miss < 255) ? m_miss + 1 : 255;
                            m_mp <= 1'b1; m_ph <= P_ADV; m_cyc <= 0;
                        end
                    end
                    P_PLAY: if (m_cyc == HT * DIV - 1) begin m_ph <= P_ADV; m_cyc <= 0; end
                    P_ADV: begin
                        m_cyc <= 0;
                        if (m_idx == SL - 1) m_ph <= P_DONE;
                        else begin m_idx <= m_idx + 1; m_ph <= P_ARM; end
                    end
                    default: m_ph <= P_IDLE;
                endcase
            end
        end
    end

    // Every-cycle comparison against the model, plus event tallies.
    always @(negedge clk) begin
        chk("note_idx",   32'(note_idx),   32'(m_idx));
        chk("note_valid", 32'(note_valid), 32'(m_ph == P_ARM || m_ph == P_WAIT || m_ph == P_PLAY));
        chk("play",       32'(play),       32'(m_ph == P_PLAY));
        chk("hit_pulse",  32'(hit_pulse),  32'(m_hp));
        chk("miss_pulse", 32'(miss_pulse), 32'(m_mp));
        chk("hit_count",  32'(hit_count),  32'(m_hits));
        chk("miss_count", 32'(miss_count), 32'(m_miss));
        chk("busy",       32'(busy),       32'(m_ph != P_IDLE && m_ph != P_DONE));
        chk("done",       32'(done),       32'(m_ph == P_DONE));
        if (hit_pulse) n_hitp++;
        if (play) n_playc++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_phase(input int ph, input string what);
        int t = 0;
        while (m_ph != ph && t < 500) begin @(negedge clk); t++; end
        chk({"reach_", what}, 32'(m_ph), 32'(ph));
    endtask

    task automatic press(input logic [7:0] k);
        wait_phase(P_WAIT, "wait");
        key = k;
        @(negedge clk);
        key = 8'h00;
    endtask

    task automatic start_song();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic set_song(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    endtask

    // Long song on the second instance: key toggles every cycle so each note is a hit.
    initial begin
        #1 rst2_n = 1'b0;
        #20 rst2_n = 1'b1;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        forever begin @(negedge clk); key2 = {7'b0, ~key2[0]}; end
    end

    initial begin
        int h0, p0, t;
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        #1 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_state", 32'({note_idx, note_valid, play, hit_pulse, miss_pulse,
                                hit_count, miss_count, busy, done}), 32'h0);

        // 1. perfect song
        set_song(8'h01, 8'h02, 8'h04, 8'h08);
        h0 = n_hitp; p0 = n_playc;
        start_song();
        for (int i = 0; i < 4; i++) press(rom[i]);
        wait_phase(P_DONE, "done1");
        chk("perfect_hits", 32'(hit_count), 32'd4);
        chk("perfect_miss", 32'(miss_count), 32'd0);
        chk("perfect_done", 32'(done), 32'd1);
        chk("perfect_idx", 32'(note_idx), 32'd3);
        chk("perfect_pulses", 32'(n_hitp - h0), 32'd4);
        chk("perfect_play_cycles", 32'(n_playc - p0), 32'd32);
        cyc(3);
        chk("done_hold_idx", 32'(note_idx), 32'd3);

        // 2. wrong key and two-key press
        set_song(8'h02, 8'h02, 8'h04, 8'h08);
        start_song();
        chk("restart_clears_hits", 32'(hit_count), 32'd0);
        press(8'h04);
        chk("wrong_key_miss", 32'(miss_pulse), 32'd1);
        chk("wrong_key_no_play", 32'(play), 32'd0);
        cyc(1);
        chk("wrong_key_adv", 32'(note_idx), 32'd1);
        press(8'h06);
        chk("two_key_miss", 32'(miss_pulse), 32'd1);

        // 3. timeout latency, then a press coinciding with the last tick
        wait_phase(P_WAIT, "wait_tmo");
        t = 0;
        while (!miss_pulse && t < 40) begin @(negedge clk); t++; end
        chk("timeout_latency", 32'(t), 32'd12);
        cyc(1);
        chk("timeout_adv", 32'(note_idx), 32'd3);
        wait_phase(P_WAIT, "wait_coinc");
        cyc(11);
        key = 8'h08;
        @(negedge clk);
        key = 8'h00;
        chk("coinc_hit", 32'(hit_pulse), 32'd1);
        chk("coinc_not_miss", 32'(miss_pulse), 32'd0);
        wait_phase(P_DONE, "done2");
        chk("song2_hits", 32'(hit_count), 32'd1);
        chk("song2_miss", 32'(miss_count), 32'd3);

        // 4. held key blocks grading of the next note
        set_song(8'h01, 8'h02, 8'h04, 8'h08);
        start_song();
        h0 = n_hitp;
        wait_phase(P_WAIT, "wait_hold");
        key = 8'h01;
        cyc(30);
        chk("held_single_hit", 32'(n_hitp - h0), 32'd1);
        chk("held_idx", 32'(note_idx), 32'd1);
        chk("held_armed", 32'({note_valid, play, busy}), 32'b101);
        key = 8'h00;
        press(8'h02);
        chk("after_release_hit", 32'(hit_count), 32'd2);

        // 5. abort in PLAY, then asynchronous reset mid-WAIT
        cyc(2);
        chk("in_play", 32'(play), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_outputs", 32'({note_valid, play, busy}), 32'd0);
        chk("abort_hits_held", 32'(hit_count), 32'd2);
        chk("abort_idx_held", 32'(note_idx), 32'd1);
        start_song();
        chk("start_clears", 32'({hit_count, 3'b0, note_idx}), 32'd0);
        press(8'h01);
        wait_phase(P_WAIT, "wait_rst");
        chk("pre_reset_hits", 32'(hit_count), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 32'({note_idx, note_valid, play, hit_pulse, miss_pulse,
                                   hit_count, miss_count, busy, done}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        start_song();
        chk("post_reset_start", 32'({busy, hit_count, 3'b0, note_idx}), 32'h10000);

        // 6. start while busy is ignored
        press(8'h01);
        start = 1'b1;
        cyc(5);
        chk("busy_start_idx", 32'(note_idx), 32'd0);
        chk("busy_start_hits", 32'(hit_count), 32'd1);
        chk("busy_start_play", 32'(play), 32'd1);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // saturation on the long song
        t = 0;
        while (!done2 && t < 6000) begin @(negedge clk); t++; end
        chk("long_done", 32'(done2), 32'd1);
        chk("long_hits_saturated", 32'(hit_count2), 32'd255);
        chk("long_miss", 32'(miss_count2), 32'd0);
        chk("long_idx", 32'(note_idx2), 32'd299);
        chk("long_idle_outs", 32'({note_valid2, play2, hit_pulse2, miss_pulse2, busy2}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
